// File: rtl/text_string.sv
`default_nettype none
// ============================================================================
// text_string : renders NCHAR 4-bit glyph codes from an external glyph ROM
//               as a registered pixel stream inside a box at (posx, posy).
// Revision    : 1.0
// ============================================================================
module text_string #(
   parameter int NCHAR      = 4,
   parameter int CHAR_W     = 16,
   parameter int CHAR_H     = 32,
   parameter int SCALE_LOG2 = 0,
   parameter int ROM_LAT    = 1,
   parameter int ROM_AW     = 10,
   parameter int ROM_DW     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           x,
   input  logic [9:0]           y,
   input  logic [9:0]           posx,
   input  logic [9:0]           posy,
   input  logic [4*NCHAR-1:0]   chars,
   input  logic                 blank_lz,
   output logic [ROM_AW-1:0]    rom_adr,
   input  logic [ROM_DW-1:0]    rom_data,
   output logic                 data,
   output logic                 active
);
   localparam int               C_BOX_W   = NCHAR * CHAR_W * (1 << SCALE_LOG2);
   localparam int               C_BOX_H   = CHAR_H * (1 << SCALE_LOG2);
   localparam int               C_COL_W   = $clog2(ROM_DW);
   localparam logic [1:0]       C_REP_MAX = 2'((1 << SCALE_LOG2) - 1);
   localparam logic [C_COL_W-1:0] C_COL_MAX = C_COL_W'(CHAR_W - 1);

   logic [4*NCHAR-1:0]   chars_q, chars_d;
   logic                 blz_q, blz_d;
   logic [3:0]           g_q, g_d;
   logic [C_COL_W-1:0]   col_q, col_d;
   logic [1:0]           rep_q, rep_d;
   logic                 armed_q, armed_d;
   logic [ROM_AW-1:0]    rom_adr_q, rom_adr_d;
   logic                 data_q, data_d;
   logic                 active_q;

   logic                 vis_pipe_q [0:ROM_LAT];
   logic                 ins_pipe_q [0:ROM_LAT];
   logic [C_COL_W-1:0]   col_pipe_q [0:ROM_LAT];

   logic [10:0]          w_x11, w_y11, w_px11, w_py11, w_dy, w_row;
   logic                 w_in, w_start;
   logic [3:0]           w_g;
   logic [C_COL_W-1:0]   w_col;
   logic [1:0]           w_rep;
   logic [3:0]           w_code;
   logic                 w_lead, w_allz, w_blank, w_vis;
   logic [ROM_AW-1:0]    w_adr;
   logic [C_COL_W-1:0]   w_bit_idx;

   assign w_x11  = {1'b0, x};
   assign w_y11  = {1'b0, y};
   assign w_px11 = {1'b0, posx};
   assign w_py11 = {1'b0, posy};

   assign w_in = (w_x11 >= w_px11) && (w_x11 < w_px11 + 11'(C_BOX_W)) &&
                 (w_y11 >= w_py11) && (w_y11 < w_py11 + 11'(C_BOX_H));
   assign w_start = w_in && (x == posx);
   assign w_dy    = w_y11 - w_py11;
   assign w_row   = w_dy >> SCALE_LOG2;

   // The row-start pixel itself must already use the freshly latched string.
   assign chars_d = w_start ? chars : chars_q;
   assign blz_d   = w_start ? blank_lz : blz_q;
   assign w_g     = w_start ? 4'd0 : g_q;
   assign w_col   = w_start ? '0 : col_q;
   assign w_rep   = w_start ? 2'd0 : rep_q;

   // Leftmost glyph sits in the most significant nibble of chars.
   always_comb begin
      w_allz = 1'b1;
      w_code = 4'h0;
      w_lead = 1'b0;
      for (int i = 0; i < NCHAR; i++) begin
         w_allz = w_allz & (chars_d[4*(NCHAR-1-i) +: 4] == 4'h0);
         if (w_g == 4'(i)) begin
            w_code = chars_d[4*(NCHAR-1-i) +: 4];
            w_lead = w_allz && (i != NCHAR - 1);
         end
      end
      w_blank = (w_code > 4'hA) || (blz_d && w_lead);
   end

   assign w_adr = ROM_AW'(w_code) * ROM_AW'(CHAR_H) + ROM_AW'(w_row);
   assign w_vis = w_in && (w_start || armed_q) && !w_blank;

   always_comb begin
      g_d       = g_q;
      col_d     = col_q;
      rep_d     = rep_q;
      armed_d   = 1'b0;
      rom_adr_d = rom_adr_q;
      if (w_in) begin
         armed_d   = w_start || armed_q;
         rom_adr_d = w_adr;
         if (w_rep == C_REP_MAX) begin
            rep_d = 2'd0;
            if (w_col == C_COL_MAX) begin
               col_d = '0;
               g_d   = w_g + 4'd1;
            end else begin
               col_d = w_col + C_COL_W'(1);
               g_d   = w_g;
            end
         end else begin
            rep_d = w_rep + 2'd1;
            col_d = w_col;
            g_d   = w_g;
         end
      end
   end

   assign w_bit_idx = C_COL_MAX - col_pipe_q[ROM_LAT];
   assign data_d    = vis_pipe_q[ROM_LAT] & rom_data[w_bit_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         chars_q   <= '0;
         blz_q     <= 1'b0;
         g_q       <= 4'd0;
         col_q     <= '0;
         rep_q     <= 2'd0;
         armed_q   <= 1'b0;
         rom_adr_q <= '0;
         data_q    <= 1'b0;
         active_q  <= 1'b0;
         for (int i = 0; i <= ROM_LAT; i++) begin
            vis_pipe_q[i] <= 1'b0;
            ins_pipe_q[i] <= 1'b0;
            col_pipe_q[i] <= '0;
         end
      end else begin
         chars_q   <= chars_d;
         blz_q     <= blz_d;
         g_q       <= g_d;
         col_q     <= col_d;
         rep_q     <= rep_d;
         armed_q   <= armed_d;
         rom_adr_q <= rom_adr_d;
         data_q    <= data_d;
         active_q  <= ins_pipe_q[ROM_LAT];
         vis_pipe_q[0] <= w_vis;
         ins_pipe_q[0] <= w_in;
         col_pipe_q[0] <= w_col;
         for (int i = 1; i <= ROM_LAT; i++) begin
            vis_pipe_q[i] <= vis_pipe_q[i-1];
            ins_pipe_q[i] <= ins_pipe_q[i-1];
            col_pipe_q[i] <= col_pipe_q[i-1];
         end
      end
   end

   assign rom_adr = rom_adr_q;
   assign data    = data_q;
   assign active  = active_q;

endmodule
`default_nettype wire

// File: tb/tb_text_string.sv
`default_nettype none
// ============================================================================
// tb_text_string : random-scan bench for text_string, two configurations
// Revision       : 1.0
// ============================================================================
module tb_text_string;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  x, y, posx, posy;
   logic [15:0] chars;
   logic        blz;
   logic [9:0]  adr0, adr1;
   logic [31:0] rd0, rd1, p1, p2;
   logic        d0, a0, d1, a1;

   logic [31:0] mem [1024];
   int          n_tests, n_fail;

   bit          armed  [2];
   logic [15:0] shc    [2];
   logic        shb    [2];
   int          adr_exp[2];
   bit          adr_ok [2];
   logic [1:0]  q0[$];
   logic [1:0]  q1[$];
   int          spec_adr[4] = '{64, 0, 128, 256};

   always #5 clk = ~clk;

   text_string u_dut0 (
      .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
      .chars(chars), .blank_lz(blz), .rom_adr(adr0), .rom_data(rd0),
      .data(d0), .active(a0));

   text_string #(.SCALE_LOG2(1), .ROM_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
      .chars(chars), .blank_lz(blz), .rom_adr(adr1), .rom_data(rd1),
      .data(d1), .active(a1));

   // Glyph ROMs: one-cycle and three-cycle read latency.
   always @(posedge clk) begin
      rd0 <= mem[adr0];
      p1  <= mem[adr1];
      p2  <= p1;
      rd1 <= p2;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t (x=%0d y=%0d)", tag, got, exp, $time, x, y);
      end
   endtask

   // Expected {active,data} for the inputs about to be clocked into configuration d.
   task automatic model_edge(input int d);
      int s, xi, yi, pxi, pyi, px, g, col, r, code, a;
      bit ins, blank, lead;
      logic [15:0] upper;
      logic [1:0]  e;
      s = d; xi = int'(x); yi = int'(y); pxi = int'(posx); pyi = int'(posy);
      e = 2'b00;
      if (rst) begin
         armed[d] = 0; shc[d] = 16'h0; shb[d] = 1'b0; adr_exp[d] = 0; adr_ok[d] = 1;
         if (d == 0) begin foreach (q0[i]) q0[i] = 2'b00; q0.push_back(e); end
         else        begin foreach (q1[i]) q1[i] = 2'b00; q1.push_back(e); end
         return;
      end
      ins = (xi >= pxi) && (xi < pxi + (64 << s)) && (yi >= pyi) && (yi < pyi + (32 << s));
      if (ins && xi == pxi) begin
         armed[d] = 1; shc[d] = chars; shb[d] = blz;
      end else if (!ins) armed[d] = 0;
      if (ins) begin
         e[1] = 1'b1;
         if (armed[d]) begin
            px    = (xi - pxi) >> s;
            g     = px / 16;
            col   = px % 16;
            r     = (yi - pyi) >> s;
            upper = shc[d] >> (4 * (3 - g));
            code  = int'(upper & 16'hF);
            lead  = (upper == 16'h0);
            blank = (code > 10) || (shb[d] && lead && g != 3);
            a     = (code * 32 + r) % 1024;
            e[0]  = !blank && mem[a][15-col];
            adr_exp[d] = a; adr_ok[d] = 1;
         end else adr_ok[d] = 0;
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic step(input logic [9:0] nx, input logic [9:0] ny, input logic nrst);
      x = nx; y = ny; rst = nrst;
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      if (q0.size() == 3) chk("pix0", {30'd0, a0, d0}, {30'd0, q0.pop_front()});
      if (q1.size() == 5) chk("pix1", {30'd0, a1, d1}, {30'd0, q1.pop_front()});
      if (adr_ok[0]) chk("adr0", {22'd0, adr0}, adr_exp[0]);
      if (adr_ok[1]) chk("adr1", {22'd0, adr1}, adr_exp[1]);
   endtask

   task automatic idle();
      repeat (6) step(10'd0, 10'd1023, 1'b0);
   endtask

   task automatic line(input int yv, input int xs, input int xe, input int rst_x,
                       input int chg_x, input logic [15:0] chg_v);
      for (int xv = xs; xv <= xe; xv++) begin
         if (xv == chg_x) chars = chg_v;
         step(10'(xv), 10'(yv), xv == rst_x);
      end
      idle();
   endtask

   initial begin
      int xs, xe, yv;
      n_tests = 0; n_fail = 0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      x = 10'd0; y = 10'd1023; posx = 10'd100; posy = 10'd50;
      chars = 16'h2048; blz = 1'b0; rst = 1'b1;
      repeat (4) step(10'd0, 10'd1023, 1'b1);
      chk("rst_adr", {22'd0, adr0}, 32'd0);
      chk("rst_data", {31'd0, d0}, 32'd0);
      chk("rst_active", {31'd0, a0}, 32'd0);
      chk("rst_active1", {31'd0, a1}, 32'd0);
      idle();

      // Top row of "2048": glyph start addresses at each glyph boundary.
      for (int xv = 95; xv < 240; xv++) begin
         step(10'(xv), 10'd50, 1'b0);
         if (xv >= 100 && xv < 164 && (xv - 100) % 16 == 0)
            chk("spec_adr", {22'd0, adr0}, spec_adr[(xv - 100) / 16]);
      end
      idle();
      line(51, 95, 240, -1, -1, 16'h0);
      line(49, 95, 240, -1, -1, 16'h0);
      line(81, 95, 240, -1, -1, 16'h0);
      line(82, 95, 240, -1, -1, 16'h0);
      line(113, 95, 240, -1, -1, 16'h0);
      line(114, 95, 240, -1, -1, 16'h0);

      // Leading-zero blanking and non-digit codes.
      chars = 16'h0008; blz = 1'b1; line(60, 95, 240, -1, -1, 16'h0);
      blz = 1'b0;                   line(60, 95, 240, -1, -1, 16'h0);
      chars = 16'h0000; blz = 1'b1; line(61, 95, 240, -1, -1, 16'h0);
      chars = 16'hF1A3; blz = 1'b0; line(62, 95, 240, -1, -1, 16'h0);
      chars = 16'h0A05; blz = 1'b1; line(63, 95, 240, -1, -1, 16'h0);

      // Mid-row string change, jump into box, and reset mid-row.
      chars = 16'h5678; blz = 1'b0; line(64, 95, 240, -1, 150, 16'h1234);
      line(65, 95, 240, -1, -1, 16'h0);
      line(66, 130, 240, -1, -1, 16'h0);
      line(67, 95, 240, 120, -1, 16'h0);
      line(68, 95, 240, -1, -1, 16'h0);

      // Box running past the right edge of the coordinate space.
      posx = 10'd1000; chars = 16'h4321; line(55, 990, 1023, -1, -1, 16'h0);

      for (int n = 0; n < 40; n++) begin
         posx  = 10'($urandom_range(0, 1023));
         posy  = 10'($urandom_range(1, 900));
         chars = 16'($urandom);
         if (n % 3 == 0) chars[15:8] = 8'h00;
         blz   = 1'($urandom);
         yv    = int'(posy) - 1 + int'($urandom_range(0, 66));
         xs    = (posx >= 3) ? int'(posx) - 3 : 0;
         xe    = int'(posx) + 132;
         if (xe > 1023) xe = 1023;
         line(yv, xs, xe, -1, xs + int'($urandom_range(5, 120)), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
